// File: rtl/multicycle_ctrl_if.sv
// Bundles the controller's datapath-facing signals: opcode, memory ready and
// ALU zero flag in one direction, control strobes and status in the other.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    // Inputs to the controller
    logic [5:0]       instr_op_i;
    logic             mem_ready_i;
    logic             zero_i;

    // Control strobes and selects to the datapath
    logic             PCWrite_o;
    logic             IRWrite_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             MemtoReg_o;
    logic             RegWrite_o;
    logic             RegDst_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [2:0]       ALU_op_o;
    logic [1:0]       PCSource_o;

    // Status
    logic [3:0]       state_o;
    logic             illegal_o;
    logic [CNT_W-1:0] instr_cnt_o;

    // Controller side
    modport master (
        input  instr_op_i, mem_ready_i, zero_i,
        output PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
               MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, PCSource_o, state_o, illegal_o, instr_cnt_o
    );

    // Datapath side
    modport slave (
        output instr_op_i, mem_ready_i, zero_i,
        input  PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
               MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, PCSource_o, state_o, illegal_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a six-opcode ISA (R-type, lw, sw, beq, addi,
// slti) driving a shared-ALU / shared-memory datapath. Memory states stall on
// mem_ready_i with a bounded wait; illegal opcodes and memory timeouts park the
// FSM in an absorbing TRAP state. Retired instructions are counted.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_IEXEC  = 4'd8,
        ST_IWB    = 4'd9,
        ST_BRANCH = 4'd10,
        ST_TRAP   = 4'd11
    } state_t;

    // Legal opcodes, packed into a table so the matchers can be generated
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam int NUM_OPS  = 6;
    localparam int OPI_RTYPE = 0;
    localparam int OPI_LW    = 1;
    localparam int OPI_SW    = 2;
    localparam int OPI_BEQ   = 3;
    localparam int OPI_ADDI  = 4;
    localparam int OPI_SLTI  = 5;
    localparam logic [6*NUM_OPS-1:0] OP_TABLE =
        {OP_SLTI, OP_ADDI, OP_BEQ, OP_SW, OP_LW, OP_RTYPE};

    // Wait counter only needs to reach TIMEOUT-1; the next miss traps
    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             stateReg;
    state_t             stateNext;
    logic [WAIT_W-1:0]  waitCntReg;
    logic [WAIT_W-1:0]  waitCntNext;
    logic [CNT_W-1:0]   instrCntReg;
    logic [CNT_W-1:0]   instrCntNext;
    logic               illegalReg;
    logic               illegalNext;

    logic [NUM_OPS-1:0] opMatch;
    logic [15:0]        inState;
    logic               isRtype;
    logic               isLw;
    logic               isSw;
    logic               isBeq;
    logic               isAddi;
    logic               isSlti;
    logic               memReady;
    logic               waitState;
    logic               waitExpired;
    logic               retire;

    // Datapath-facing control values before reset gating
    logic               pcWrite;
    logic               irWrite;
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               memtoReg;
    logic               regWrite;
    logic               regDst;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [2:0]         aluOp;
    logic [1:0]         pcSource;

    genvar gi;

    // One comparator per legal opcode
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_opMatch
            assign opMatch[gi] = (bus.instr_op_i == OP_TABLE[gi*6 +: 6]);
        end
    endgenerate

    assign isRtype = opMatch[OPI_RTYPE];
    assign isLw    = opMatch[OPI_LW];
    assign isSw    = opMatch[OPI_SW];
    assign isBeq   = opMatch[OPI_BEQ];
    assign isAddi  = opMatch[OPI_ADDI];
    assign isSlti  = opMatch[OPI_SLTI];

    // One-hot view of the state register, including the unreachable codes
    generate
        for (gi = 0; gi < 16; gi++) begin : g_inState
            assign inState[gi] = (4'(stateReg) == 4'(gi));
        end
    endgenerate

    assign memReady    = bus.mem_ready_i;
    assign waitState   = inState[ST_FETCH] | inState[ST_MEMRD] | inState[ST_MEMWR];
    // A ready in the last allowed cycle still wins over the timeout
    assign waitExpired = waitState & ~memReady & (waitCntReg == WAIT_LAST);
    // Retire on the edge that leaves the last step of a completed instruction
    assign retire      = inState[ST_MEMWB] | inState[ST_RWB] | inState[ST_IWB] |
                         inState[ST_BRANCH] | (inState[ST_MEMWR] & memReady);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateReg <= ST_FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_FETCH: begin
                if (memReady) begin
                    stateNext = ST_DECODE;
                end else if (waitExpired) begin
                    stateNext = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (isRtype) begin
                    stateNext = ST_EXEC;
                end else if (isLw || isSw) begin
                    stateNext = ST_MEMADR;
                end else if (isBeq) begin
                    stateNext = ST_BRANCH;
                end else if (isAddi || isSlti) begin
                    stateNext = ST_IEXEC;
                end else begin
                    stateNext = ST_TRAP;
                end
            end
            ST_MEMADR: stateNext = isLw ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (memReady) begin
                    stateNext = ST_MEMWB;
                end else if (waitExpired) begin
                    stateNext = ST_TRAP;
                end
            end
            ST_MEMWR: begin
                if (memReady) begin
                    stateNext = ST_FETCH;
                end else if (waitExpired) begin
                    stateNext = ST_TRAP;
                end
            end
            ST_MEMWB:  stateNext = ST_FETCH;
            ST_EXEC:   stateNext = ST_RWB;
            ST_RWB:    stateNext = ST_FETCH;
            ST_IEXEC:  stateNext = ST_IWB;
            ST_IWB:    stateNext = ST_FETCH;
            ST_BRANCH: stateNext = ST_FETCH;
            ST_TRAP:   stateNext = ST_TRAP;
            default:   stateNext = ST_TRAP;
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        iorD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memtoReg = 1'b0;
        regWrite = 1'b0;
        regDst   = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        aluOp    = 3'b000;
        pcSource = 2'b00;
        case (stateReg)
            ST_FETCH: begin
                // PC+4 is computed every cycle but only latched with the IR
                memRead = 1'b1;
                aluSrcB = 2'b01;
                aluOp   = 3'b001;
                irWrite = memReady;
                pcWrite = memReady;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                aluSrcB = 2'b11;
                aluOp   = 3'b001;
            end
            ST_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = isLw ? 3'b011 : 3'b100;
            end
            ST_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            ST_MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
            end
            ST_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            ST_EXEC: begin
                aluSrcA = 1'b1;
            end
            ST_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            ST_IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = isSlti ? 3'b010 : 3'b001;
            end
            ST_IWB: begin
                regWrite = 1'b1;
            end
            ST_BRANCH: begin
                aluSrcA  = 1'b1;
                aluOp    = 3'b101;
                pcSource = 2'b01;
                pcWrite  = bus.zero_i;
            end
            default: begin
                // TRAP and unreachable codes drive nothing
            end
        endcase
    end

    // Wait counter, illegal flag and retire counter next values
    always_comb begin
        waitCntNext  = waitCntReg;
        illegalNext  = illegalReg;
        instrCntNext = instrCntReg;
        // Any state change restarts the count, so each wait state starts at zero
        if (stateNext != stateReg) begin
            waitCntNext = '0;
        end else if (waitState && !memReady) begin
            waitCntNext = waitCntReg + WAIT_W'(1);
        end
        if (stateNext == ST_TRAP) begin
            illegalNext = 1'b1;
        end
        if (retire) begin
            instrCntNext = instrCntReg + CNT_W'(1);
        end
    end

    // Wait counter, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waitCntReg  <= '0;
            illegalReg  <= 1'b0;
            instrCntReg <= '0;
        end else begin
            waitCntReg  <= waitCntNext;
            illegalReg  <= illegalNext;
            instrCntReg <= instrCntNext;
        end
    end

    // Load strobes are suppressed while reset is held
    assign bus.PCWrite_o   = pcWrite & ~rst_i;
    assign bus.IRWrite_o   = irWrite & ~rst_i;
    assign bus.IorD_o      = iorD;
    assign bus.MemRead_o   = memRead;
    assign bus.MemWrite_o  = memWrite;
    assign bus.MemtoReg_o  = memtoReg;
    assign bus.RegWrite_o  = regWrite;
    assign bus.RegDst_o    = regDst;
    assign bus.ALUSrcA_o   = aluSrcA;
    assign bus.ALUSrcB_o   = aluSrcB;
    assign bus.ALU_op_o    = aluOp;
    assign bus.PCSource_o  = pcSource;
    assign bus.state_o     = stateReg;
    assign bus.illegal_o   = illegalReg;
    assign bus.instr_cnt_o = instrCntReg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instructions plus a random run,
// each instruction expanded into its expected per-cycle state walk and the
// control values listed for each state, compared every cycle.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 6;    // small counter so the wrap is reachable
    localparam int BIG     = 100000;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC   = 6;
    localparam int S_RWB    = 7;
    localparam int S_IEXEC  = 8;
    localparam int S_IWB    = 9;
    localparam int S_BRANCH = 10;
    localparam int S_TRAP   = 11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;
    int modelCnt = 0;
    int seqState[$];
    bit seqRdy[$];
    logic [5:0] legalOps [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control values each state is documented to present
    function automatic ctrl_t expCtrl(input int st, input logic [5:0] op,
                                      input logic rdy, input logic z, input logic inRst);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = 3'b001;
                c.irWrite = rdy & ~inRst; c.pcWrite = rdy & ~inRst;
            end
            S_DECODE: begin c.aluSrcB = 2'b11; c.aluOp = 3'b001; end
            S_MEMADR: begin
                c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
                c.aluOp = (op == OP_LW) ? 3'b011 : 3'b100;
            end
            S_MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
            S_MEMWB:  begin c.regWrite = 1'b1; c.memtoReg = 1'b1; end
            S_MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
            S_EXEC:   begin c.aluSrcA = 1'b1; end
            S_RWB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            S_IEXEC: begin
                c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
                c.aluOp = (op == OP_SLTI) ? 3'b010 : 3'b001;
            end
            S_IWB:    begin c.regWrite = 1'b1; end
            S_BRANCH: begin
                c.aluSrcA = 1'b1; c.aluOp = 3'b101; c.pcSource = 2'b01; c.pcWrite = z;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obsCtrl();
        return {bus.PCWrite_o, bus.IRWrite_o, bus.IorD_o, bus.MemRead_o,
                bus.MemWrite_o, bus.MemtoReg_o, bus.RegWrite_o, bus.RegDst_o,
                bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALU_op_o, bus.PCSource_o};
    endfunction

    // A state that does not care about ready gets a random one
    task automatic pushStep(input int st);
        seqState.push_back(st);
        seqRdy.push_back(1'($urandom_range(0, 1)));
    endtask

    // A memory-wait state: `waits` not-ready cycles then a ready one,
    // or a timeout once the wait reaches TIMEOUT cycles
    task automatic pushWait(input int st, input int waits, output bit trapped);
        trapped = 1'b0;
        if (waits >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                seqState.push_back(st);
                seqRdy.push_back(1'b0);
            end
            trapped = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) begin
                seqState.push_back(st);
                seqRdy.push_back(1'b0);
            end
            seqState.push_back(st);
            seqRdy.push_back(1'b1);
        end
    endtask

    // Called at a negedge; runs one instruction (or up to maxCycles of it)
    task automatic runInstr(input string name, input logic [5:0] op, input int fetchWaits,
                            input int memWaits, input logic z, input int trapCycles,
                            input int maxCycles);
        bit trapped;
        int n;
        ctrl_t exp;
        seqState.delete();
        seqRdy.delete();
        pushWait(S_FETCH, fetchWaits, trapped);
        if (!trapped) begin
            pushStep(S_DECODE);
            case (op)
                OP_RTYPE: begin pushStep(S_EXEC); pushStep(S_RWB); end
                OP_LW: begin
                    pushStep(S_MEMADR);
                    pushWait(S_MEMRD, memWaits, trapped);
                    if (!trapped) pushStep(S_MEMWB);
                end
                OP_SW: begin
                    pushStep(S_MEMADR);
                    pushWait(S_MEMWR, memWaits, trapped);
                end
                OP_BEQ: pushStep(S_BRANCH);
                OP_ADDI, OP_SLTI: begin pushStep(S_IEXEC); pushStep(S_IWB); end
                default: trapped = 1'b1;
            endcase
        end
        if (trapped) begin
            for (int i = 0; i < trapCycles; i++) pushStep(S_TRAP);
        end
        n = (seqState.size() < maxCycles) ? seqState.size() : maxCycles;
        for (int i = 0; i < n; i++) begin
            bus.instr_op_i  = op;
            bus.mem_ready_i = seqRdy[i];
            bus.zero_i      = z;
            #1;
            exp = expCtrl(seqState[i], op, seqRdy[i], z, 1'b0);
            check($sformatf("%s c%0d state", name, i), 32'(bus.state_o), 32'(seqState[i]));
            check($sformatf("%s c%0d ctrl", name, i), 32'(obsCtrl()), 32'(exp));
            check($sformatf("%s c%0d cnt", name, i), 32'(bus.instr_cnt_o), 32'(modelCnt));
            check($sformatf("%s c%0d illegal", name, i), 32'(bus.illegal_o),
                  32'(seqState[i] == S_TRAP));
            @(negedge clk);
        end
        if (!trapped && n == seqState.size()) begin
            modelCnt = (modelCnt + 1) % (1 << CNT_W);
        end
        $display("instr %s op=%b fw=%0d mw=%0d z=%b cycles=%0d trapped=%0d cnt=%0d",
                 name, op, fetchWaits, memWaits, z, n, trapped, modelCnt);
    endtask

    // Called at a negedge; asynchronous reset checked immediately and across an edge
    task automatic doReset(input string name);
        rst = 1'b1;
        bus.mem_ready_i = 1'b1;
        #1;
        check({name, " rst state"}, 32'(bus.state_o), 32'(S_FETCH));
        check({name, " rst ctrl"}, 32'(obsCtrl()),
              32'(expCtrl(S_FETCH, bus.instr_op_i, 1'b1, bus.zero_i, 1'b1)));
        check({name, " rst cnt"}, 32'(bus.instr_cnt_o), 32'd0);
        check({name, " rst illegal"}, 32'(bus.illegal_o), 32'd0);
        @(negedge clk);
        check({name, " rst held state"}, 32'(bus.state_o), 32'(S_FETCH));
        rst = 1'b0;
        modelCnt = 0;
        $display("reset %s", name);
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_op_i  = OP_RTYPE;
        bus.mem_ready_i = 1'b1;
        bus.zero_i      = 1'b0;
        @(negedge clk);
        doReset("init");

        runInstr("rtype", OP_RTYPE, 0, 0, 1'b0, 0, BIG);
        runInstr("lw22", OP_LW, 2, 2, 1'b0, 0, BIG);
        runInstr("sw", OP_SW, 1, 1, 1'b0, 0, BIG);
        runInstr("beqZ1", OP_BEQ, 0, 0, 1'b1, 0, BIG);
        runInstr("beqZ0", OP_BEQ, 0, 0, 1'b0, 0, BIG);
        runInstr("addi", OP_ADDI, 0, 0, 1'b0, 0, BIG);
        runInstr("slti", OP_SLTI, 0, 0, 1'b0, 0, BIG);

        // Long run without reset: the retire counter passes 2^CNT_W and wraps
        for (int k = 0; k < 70; k++) begin
            runInstr("rand", legalOps[$urandom_range(0, 5)], $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, BIG);
        end

        // Illegal opcode: absorbing trap with frozen counter
        runInstr("illegal", 6'b111111, 1, 0, 1'b0, 20, BIG);
        doReset("afterIllegal");

        // Fetch timeout, then ready on the last allowed cycle
        runInstr("fetchTimeout", OP_RTYPE, TIMEOUT, 0, 1'b0, 3, BIG);
        doReset("afterTimeout");
        runInstr("fetchLastReady", OP_RTYPE, TIMEOUT - 1, 0, 1'b0, 0, BIG);

        // Memory-read timeout
        runInstr("memrdTimeout", OP_LW, 0, TIMEOUT, 1'b0, 3, BIG);
        doReset("afterMemTimeout");

        // Reset during a stalled store: abandoned, no write after reset
        runInstr("swAbort", OP_SW, 0, 6, 1'b0, 0, 5);
        doReset("midStore");
        runInstr("beqAfter", OP_BEQ, 0, 0, 1'b1, 0, BIG);
        bus.mem_ready_i = 1'b0;
        #1;
        check("final cnt", 32'(bus.instr_cnt_o), 32'(modelCnt));

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
